inst_type_imm_gen: RTL and testbench

- Front-end helper for the RV64 decoder.
- Classifies a 32-bit instruction into its base format (R/I/S/B/U/J/none) from the opcode.
- Reconstructs the 64-bit sign-extended immediate for that format.
- Result is registered once so the decoder consumes a stable type/immediate pair on the next clock edge.

---
 rtl/inst_type_imm_gen.sv | 57 +++++
 tb/tb_inst_type_imm_gen.sv | 79 +++++++
 2 files changed

// File: rtl/inst_type_imm_gen.sv
// inst_type_imm_gen: classify an RV64 instruction format and register its sign-extended immediate
module inst_type_imm_gen #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     inst,
  output logic            out_valid,
  output logic [2:0]      inst_type,
  output logic [XLEN-1:0] imm
);
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_NONE = 3'd7;
  logic [2:0]      type_d, type_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic            valid_d, valid_q;
  // map the opcode to a format; unlisted opcodes fall to NONE
  always_comb begin
    case (inst[6:0])
      7'b0110011, 7'b0111011: type_d = T_R;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: type_d = T_I;
      7'b0100011: type_d = T_S;
      7'b1100011: type_d = T_B;
      7'b0110111, 7'b0010111: type_d = T_U;
      7'b1101111: type_d = T_J;
      default: type_d = T_NONE;
    endcase
  end
  // reassemble the immediate for the decoded format and pick the next register state
  always_comb begin
    imm_d = type_d == T_I ? {{52{inst[31]}}, inst[31:20]} :
            type_d == T_S ? {{52{inst[31]}}, inst[31:25], inst[11:7]} :
            type_d == T_B ? {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
            type_d == T_U ? {{32{inst[31]}}, inst[31:12], 12'b0} :
            type_d == T_J ? {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
            '0;
    valid_d = in_valid;
  end
  // single result stage: load on valid, otherwise hold the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q  <= T_NONE;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (in_valid) begin
        type_q <= type_d;
        imm_q  <= imm_d;
      end
    end
  end
  assign out_valid = valid_q;
  assign inst_type = type_q;
  assign imm       = imm_q;
endmodule

// File: tb/tb_inst_type_imm_gen.sv
// tb_inst_type_imm_gen: directed checks of format classification, immediates, hold and reset
module tb_inst_type_imm_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst;
  logic        out_valid;
  logic [2:0]  inst_type;
  logic [63:0] imm;
  int          passed = 0;
  int          total = 0;
  inst_type_imm_gen #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst),
    .out_valid(out_valid), .inst_type(inst_type), .imm(imm)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic ev, input logic [2:0] et, input logic [63:0] ei);
    total++;
    assert (out_valid === ev) passed++;
    else $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, ev);
    total++;
    assert (inst_type === et) passed++;
    else $error("FAIL %s inst_type got %0d want %0d", tag, inst_type, et);
    total++;
    assert (imm === ei) passed++;
    else $error("FAIL %s imm got %h want %h", tag, imm, ei);
  endtask
  task automatic step(input string tag, input logic [31:0] w, input logic [2:0] et, input logic [63:0] ei);
    inst = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk(tag, 1'b1, et, ei);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    inst = 32'hFFF00093;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", 1'b0, 3'd7, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_addi", 1'b1, 3'd1, 64'hFFFFFFFFFFFFFFFF);
    step("ebreak", 32'h00100073, 3'd1, 64'h1);
    step("mret", 32'h30200073, 3'd1, 64'h302);
    step("ecall", 32'h00000073, 3'd1, 64'h0);
    step("sd", 32'hFE20BC23, 3'd2, 64'hFFFFFFFFFFFFFFF8);
    step("beq", 32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC);
    step("jal", 32'h001000EF, 3'd5, 64'h800);
    step("add", 32'h002081B3, 3'd0, 64'h0);
    step("bad_op", 32'h0000007F, 3'd7, 64'h0);
    step("slli_raw", 32'h40209093, 3'd1, 64'h402);
    step("auipc", 32'h12345097, 3'd4, 64'h12345000);
    step("lui_neg", 32'h800000B7, 3'd4, 64'hFFFFFFFF80000000);
    in_valid = 1'b0;
    inst = 32'hFFFFFFEF;
    #2;
    chk("no_comb_path", 1'b1, 3'd4, 64'hFFFFFFFF80000000);
    for (int k = 0; k < 3; k++) begin
      inst = $urandom;
      @(posedge clk);
      #1;
      chk("hold", 1'b0, 3'd4, 64'hFFFFFFFF80000000);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    inst = 32'h001000EF;
    @(posedge clk);
    #1;
    chk("mid_reset", 1'b0, 3'd7, 64'h0);
    rst = 1'b0;
    step("resume_sw", 32'h00112423, 3'd2, 64'h8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
